load_ext_unit: RTL

- Parametrised load-data unit for the MIPS datapath; next generation of the combinational byte/half/word extractor.
- Accepts a load request (address, size, signedness) and fetches the bytes over a memory read port of width BUS_W, taking one or more handshaked beats.
- Assembles the little-endian result, then sign- or zero-extends it to DATA_W.
- Sits between the MEM-stage load request and the writeback register, with valid/ready on both sides.

---
 rtl/load_ext_unit.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/load_ext_unit.sv
// load_ext_unit: handshaked load-data unit that fetches 1..N beats of BUS_W bits and sign/zero-extends
// the little-endian result to DATA_W. Define LOAD_EXT_TIMEOUT_EN to add the mem_ack watchdog.
`timescale 1ns/1ps
module load_ext_unit #(
  parameter int DATA_W  = 32,
  parameter int BUS_W   = 8,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_mode,
  input  logic              req_unsigned,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [BUS_W-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  // state | meaning
  // IDLE  | waiting for a load request; req_ready high
  // FETCH | issuing beat reads until the last mem_ack (or watchdog expiry)
  // RESP  | rsp_valid high, result held until rsp_ready

  localparam int BYTES_W    = DATA_W / 8;
  localparam int MAX_BEATS  = DATA_W / BUS_W;
  localparam int ASM_W      = MAX_BEATS * BUS_W;
  localparam int LANE_W     = (BUS_W > 8) ? $clog2(BUS_W / 8) : 1;
  localparam int CNT_W      = $clog2(MAX_BEATS + 1);
  localparam int HALF_BEATS = (BUS_W == 8) ? 2 : 1;

  localparam logic [1:0] MODE_WORD = 2'b00;
  localparam logic [1:0] MODE_BYTE = 2'b01;
  localparam logic [1:0] MODE_HALF = 2'b10;

  if (DATA_W < 32 || (DATA_W % 8) != 0) begin : g_bad_data_w
    $error("load_ext_unit: DATA_W must be a multiple of 8 and at least 32");
  end
  if (BUS_W < 8 || BUS_W > DATA_W || (BUS_W & (BUS_W - 1)) != 0) begin : g_bad_bus_w
    $error("load_ext_unit: BUS_W must be a power of two in 8..DATA_W");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("load_ext_unit: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RESP} state_t;

  state_t             state_q;
  logic [1:0]         mode_q;
  logic               unsigned_q;
  logic [LANE_W-1:0]  lane_q;
  logic [CNT_W-1:0]   nbeats_q;
  logic [CNT_W-1:0]   beat_q;
  logic [ASM_W-1:0]   asm_q;

  logic [LANE_W-1:0]  lane_in;
  logic [ADDR_W-1:0]  base_in;
  logic [ADDR_W-1:0]  word_off;
  logic               req_err;
  logic [CNT_W-1:0]   nbeats_in;
  logic [ASM_W-1:0]   asm_next;
  logic [ASM_W-1:0]   shifted;
  logic [DATA_W-1:0]  ext_data;
  logic [CNT_W-1:0]   beat_inc;
  logic               last_beat;

  // With an 8-bit bus every byte is its own beat, so there is no lane field to select.
  if (BUS_W > 8) begin : g_lane
    assign lane_in = req_addr[LANE_W-1:0];
    assign base_in = {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
  end else begin : g_no_lane
    assign lane_in = '0;
    assign base_in = req_addr;
  end

  assign word_off  = req_addr % ADDR_W'(BYTES_W);
  assign req_ready = (state_q == S_IDLE);
  assign beat_inc  = beat_q + CNT_W'(1);
  assign last_beat = (beat_inc == nbeats_q);

  always_comb begin
    req_err   = 1'b0;
    nbeats_in = CNT_W'(1);
    case (req_mode)
      MODE_BYTE: req_err = 1'b0;
      MODE_HALF: begin
        req_err   = req_addr[0];
        nbeats_in = CNT_W'(HALF_BEATS);
      end
      MODE_WORD: begin
        req_err   = (word_off != '0);
        nbeats_in = CNT_W'(MAX_BEATS);
      end
      default:   req_err = 1'b1;
    endcase
  end

  // The final beat is folded in combinationally so the result registers on the last ack edge.
  always_comb begin
    asm_next = asm_q;
    asm_next[int'(beat_q) * BUS_W +: BUS_W] = mem_rdata;
  end

  assign shifted = asm_next >> {lane_q, 3'b000};

  always_comb begin
    ext_data = DATA_W'(shifted);
    case (mode_q)
      MODE_BYTE: ext_data = {{(DATA_W - 8){~unsigned_q & shifted[7]}}, shifted[7:0]};
      MODE_HALF: ext_data = {{(DATA_W - 16){~unsigned_q & shifted[15]}}, shifted[15:0]};
      default:   ext_data = DATA_W'(shifted);
    endcase
  end

`ifdef LOAD_EXT_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= MODE_WORD;
      unsigned_q <= 1'b0;
      lane_q     <= '0;
      nbeats_q   <= '0;
      beat_q     <= '0;
      asm_q      <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
`ifdef LOAD_EXT_TIMEOUT_EN
      wait_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            mode_q     <= req_mode;
            unsigned_q <= req_unsigned;
            lane_q     <= lane_in;
            nbeats_q   <= nbeats_in;
            beat_q     <= '0;
            asm_q      <= '0;
            if (req_err) begin
              state_q   <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
            end else begin
              state_q  <= S_FETCH;
              mem_rd   <= 1'b1;
              mem_addr <= base_in;
`ifdef LOAD_EXT_TIMEOUT_EN
              wait_q   <= WAIT_W'(TIMEOUT - 1);
`endif
            end
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            asm_q    <= asm_next;
            beat_q   <= beat_inc;
            mem_addr <= mem_addr + ADDR_W'(BUS_W / 8);
`ifdef LOAD_EXT_TIMEOUT_EN
            wait_q   <= WAIT_W'(TIMEOUT - 1);
`endif
            if (last_beat) begin
              state_q   <= S_RESP;
              mem_rd    <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_data  <= ext_data;
            end
          end
`ifdef LOAD_EXT_TIMEOUT_EN
          // Down-counter reaches terminal count after TIMEOUT ack-less cycles on one beat.
          else if (wait_q == '0) begin
            state_q   <= S_RESP;
            mem_rd    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q   <= S_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
